bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Two-master arbiter and access sequencer in front of the Bridge data port.
- Masters: m0 is the CPU data port; m1 is the debug/DMA loader.
- Serialises accesses and grants them round-robin.
- Byte and half-word stores run as an in-block read-modify-write, so masters only ever see word-granular bus semantics.

Parameters:
- ADDR_W, 32, address width of masters and bus.
- DATA_W, 32, data width; fixed at 32 (byte lanes assume 4 bytes).

Ports:
- cpu_clk  in  1  clock
- cpu_rst  in  1  synchronous active-high reset
- m0_req  in  1  CPU request; held until m0_done
- m0_we  in  1  1=store, 0=load
- m0_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- m0_addr  in  ADDR_W  byte address
- m0_wdata  in  DATA_W  store data, right-aligned (byte in [7:0], half in [15:0])
- m0_gnt  out  1  one-cycle pulse when m0 request accepted
- m0_done  out  1  one-cycle completion pulse
- m0_rdata  out  DATA_W  aligned word read; valid while m0_done=1
- m1_req, m1_we, m1_size, m1_addr, m1_wdata, m1_gnt, m1_done, m1_rdata  same as m0, for master 1
- bus_addr  out  ADDR_W  word-aligned address to Bridge
- bus_we  out  1  Bridge write strobe; write commits on the cpu_clk edge while high
- bus_wdata  out  DATA_W  full word to write
- bus_rdata  in  DATA_W  Bridge read data; valid the cycle after bus_addr is presented

Behaviour:
- All outputs are registered.
- Reset: state=IDLE; all gnt/done, bus_we=0; bus_addr, bus_wdata, rdata=0; round-robin pointer set so m0 wins first tie.
- States: IDLE, RD, RCAP, WR, DONE.
- IDLE:
  - If any req: pick winner; latch we, size, addr, wdata and master id; pulse that master's gnt for one cycle.
  - Next state: WR for word store, RD otherwise.
  - No req: stay in IDLE.
- Arbitration:
  - Single requester wins.
  - Both requesting: the master not granted last time wins.
  - Pointer updates only on grant.
- RD: bus_addr={addr[31:2],2'b00}, bus_we=0 → RCAP.
- RCAP:
  - bus_addr held; capture bus_rdata into rdata_q.
  - Load → DONE.
  - Sub-word store → build merged word from bus_rdata, then → WR.
- Merge rules:
  - Byte: lane addr[1:0] gets wdata[7:0]; other lanes from bus_rdata.
  - Half: addr[1]=0 → [15:0], addr[1]=1 → [31:16]; addr[0] ignored.
- WR: bus_we=1 for exactly one cycle; bus_wdata = wdata (word) or merged word → DONE.
- DONE:
  - Pulse the owning master's done.
  - That master's rdata = rdata_q for loads; unchanged for stores.
  - No arbitration in DONE → IDLE.
- Latency from the cycle req is sampled in IDLE to the done cycle:
  - Word store: 2 cycles (IDLE, WR, DONE).
  - Load: 3 cycles.
  - Sub-word store: 4 cycles.
- Word accesses ignore addr[1:0]; bus_addr[1:0] is always 00.
- Loads always return the full aligned word; the master performs lane extraction and sign extension.
- Outside RD/RCAP/WR: bus_we=0, bus_addr=0, bus_wdata=0.
- Req semantics:
  - Masters drop req in the DONE cycle.
  - Req still high in the following IDLE is a new request.
  - A req deasserted after gnt does not abort; the transaction completes and done still pulses.
  - The non-owner's req is ignored until IDLE.
- Simultaneous events: a request arriving while the other transaction is in DONE waits for IDLE and is served there.
- Reset mid-operation: the next edge forces IDLE with bus_we=0; a pending write not yet in WR never commits; no done pulse.

Test Plan:
- m0 word store addr 0x104, data 0xDEADBEEF → gnt at c0, bus_we=1 at c1 with bus_addr=0x104, m0_done at c2; memory word = 0xDEADBEEF.
- Memory[0x100]=0x11223344; m0 byte store addr 0x102, data 0xAA → RD/RCAP at c1–c2, WR at c3 with bus_wdata=0x11AA3344, done at c4.
- Memory[0x200]=0x55667788; m1 half store addr 0x203, data 0xBEEF → bus_wdata=0xBEEF7788 (addr[0] ignored); m1_done at c4, m0 outputs untouched.
- Memory[0x300]=0xCAFEF00D; m0 load addr 0x301 → bus_addr=0x300, m0_done at c3 with m0_rdata=0xCAFEF00D.
- m0 and m1 both request continuously from reset → grant order m0, m1, m0, m1; no overlapping bus cycles; each done in the correct master's port.
- cpu_rst asserted during RCAP of a byte store → next cycle IDLE, bus_we never high, memory unchanged, no done; a subsequent request is served normally.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter that serialises word-granular accesses onto the
// Bridge port; byte/half stores are turned into an internal read-modify-write.
module bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [1:0]        m0_size,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_done,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [1:0]        m1_size,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_done,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_we,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_RCAP, S_WR, S_DONE} state_t;

  state_t            state_reg, state_next;
  logic              owner_reg, owner_next;
  logic              last_reg, last_next;
  logic              we_reg, we_next;
  logic [1:0]        size_reg, size_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic [1:0]        gnt_reg, gnt_next;
  logic [1:0]        done_reg, done_next;
  logic [DATA_W-1:0] rdata_reg [2];
  logic [DATA_W-1:0] rdata_next [2];
  logic [ADDR_W-1:0] bus_addr_reg, bus_addr_next;
  logic              bus_we_reg, bus_we_next;
  logic [DATA_W-1:0] bus_wdata_reg, bus_wdata_next;

  logic [1:0]        req_vec;
  logic [1:0]        we_vec;
  logic [1:0]        size_arr [2];
  logic [ADDR_W-1:0] addr_arr [2];
  logic [DATA_W-1:0] wdata_arr [2];
  logic              win;
  logic              is_byte, is_half;
  logic [ADDR_W-1:0] aligned_addr;
  logic [DATA_W-1:0] merged;

  assign req_vec      = {m1_req, m0_req};
  assign we_vec       = {m1_we, m0_we};
  assign size_arr[0]  = m0_size;
  assign size_arr[1]  = m1_size;
  assign addr_arr[0]  = m0_addr;
  assign addr_arr[1]  = m1_addr;
  assign wdata_arr[0] = m0_wdata;
  assign wdata_arr[1] = m1_wdata;

  // last_reg holds the id granted last; on a tie the other master wins.
  assign win = req_vec[1] & (~req_vec[0] | ~last_reg);

  assign is_byte      = (size_reg == 2'b00);
  assign is_half      = (size_reg == 2'b01);
  assign aligned_addr = {addr_reg[ADDR_W-1:2], 2'b00};

  // Lane merge: written lanes take store data, the rest come from the read word.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE    = 2'(gi);
    localparam logic       HALF_HI = (gi >= 2);
    logic lane_hit;
    logic [7:0] lane_data;
    assign lane_hit  = size_reg[1]
                     | (is_byte & (addr_reg[1:0] == LANE))
                     | (is_half & (addr_reg[1] == HALF_HI));
    assign lane_data = size_reg[1] ? wdata_reg[8*gi +: 8] :
                       is_byte     ? wdata_reg[7:0]       :
                                     wdata_reg[8*(gi%2) +: 8];
    assign merged[8*gi +: 8] = lane_hit ? lane_data : bus_rdata[8*gi +: 8];
  end

  always_comb begin
    state_next     = state_reg;
    owner_next     = owner_reg;
    last_next      = last_reg;
    we_next        = we_reg;
    size_next      = size_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    gnt_next       = 2'b00;
    done_next      = 2'b00;
    rdata_next[0]  = rdata_reg[0];
    rdata_next[1]  = rdata_reg[1];
    bus_addr_next  = '0;
    bus_we_next    = 1'b0;
    bus_wdata_next = '0;
    case (state_reg)
      S_IDLE: begin
        if (|req_vec) begin
          owner_next    = win;
          last_next     = win;
          we_next       = we_vec[win];
          size_next     = size_arr[win];
          addr_next     = addr_arr[win];
          wdata_next    = wdata_arr[win];
          gnt_next[win] = 1'b1;
          bus_addr_next = {addr_arr[win][ADDR_W-1:2], 2'b00};
          if (we_vec[win] && size_arr[win][1]) begin
            state_next     = S_WR;
            bus_we_next    = 1'b1;
            bus_wdata_next = wdata_arr[win];
          end else begin
            state_next = S_RD;
          end
        end
      end
      S_RD: begin
        state_next    = S_RCAP;
        bus_addr_next = aligned_addr;
      end
      S_RCAP: begin
        bus_addr_next = aligned_addr;
        if (we_reg) begin
          state_next     = S_WR;
          bus_we_next    = 1'b1;
          bus_wdata_next = merged;
        end else begin
          state_next            = S_DONE;
          done_next[owner_reg]  = 1'b1;
          rdata_next[owner_reg] = bus_rdata;
        end
      end
      S_WR: begin
        state_next           = S_DONE;
        done_next[owner_reg] = 1'b1;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_reg     <= S_IDLE;
      owner_reg     <= 1'b0;
      last_reg      <= 1'b1;
      we_reg        <= 1'b0;
      size_reg      <= 2'b00;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      gnt_reg       <= 2'b00;
      done_reg      <= 2'b00;
      rdata_reg[0]  <= '0;
      rdata_reg[1]  <= '0;
      bus_addr_reg  <= '0;
      bus_we_reg    <= 1'b0;
      bus_wdata_reg <= '0;
    end else begin
      state_reg     <= state_next;
      owner_reg     <= owner_next;
      last_reg      <= last_next;
      we_reg        <= we_next;
      size_reg      <= size_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      gnt_reg       <= gnt_next;
      done_reg      <= done_next;
      rdata_reg[0]  <= rdata_next[0];
      rdata_reg[1]  <= rdata_next[1];
      bus_addr_reg  <= bus_addr_next;
      bus_we_reg    <= bus_we_next;
      bus_wdata_reg <= bus_wdata_next;
    end
  end

  assign m0_gnt    = gnt_reg[0];
  assign m1_gnt    = gnt_reg[1];
  assign m0_done   = done_reg[0];
  assign m1_done   = done_reg[1];
  assign m0_rdata  = rdata_reg[0];
  assign m1_rdata  = rdata_reg[1];
  assign bus_addr  = bus_addr_reg;
  assign bus_we    = bus_we_reg;
  assign bus_wdata = bus_wdata_reg;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed and random accesses against a word-memory
// reference model, plus round-robin streaming and mid-transaction reset.
module tb_bus_arbiter;

  logic        cpu_clk;
  logic        cpu_rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [1:0]  m0_size, m1_size;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_done, m1_gnt, m1_done;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_we;

  logic [31:0] mem [0:255];
  logic [31:0] ref_mem [0:255];
  logic [31:0] exp_rdata [2];
  logic        mem_clr;
  int          n_pass;
  int          n_checks;

  bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_rdata(m1_rdata),
    .bus_addr(bus_addr), .bus_we(bus_we), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  // Bridge: registered read one cycle after the address, write on the edge.
  always @(posedge cpu_clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (bus_we) begin
      mem[bus_addr[9:2]] <= bus_wdata;
    end
    bus_rdata <= mem[bus_addr[9:2]];
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %08h required %08h", tag, obs, exp);
  endtask

  function automatic logic gnt_of(input int m);
    return (m == 1) ? m1_gnt : m0_gnt;
  endfunction

  function automatic logic done_of(input int m);
    return (m == 1) ? m1_done : m0_done;
  endfunction

  function automatic logic [31:0] rdata_of(input int m);
    return (m == 1) ? m1_rdata : m0_rdata;
  endfunction

  // Cycles from the IDLE sample cycle to the done cycle.
  function automatic int model_lat(input logic we, input logic [1:0] sz);
    if (!we) return 3;
    return sz[1] ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] old, input logic [1:0] sz,
                                              input logic [31:0] a, input logic [31:0] wd);
    int sh;
    logic [31:0] mask;
    case (sz)
      2'b00: begin sh = 8 * int'(a[1:0]); mask = 32'h0000_00FF << sh; end
      2'b01: begin sh = 16 * int'(a[1]);  mask = 32'h0000_FFFF << sh; end
      default: return wd;
    endcase
    return (old & ~mask) | ((wd << sh) & mask);
  endfunction

  task automatic drive(input int m, input logic r, input logic we, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] d);
    if (m == 0) begin
      m0_req = r; m0_we = we; m0_size = sz; m0_addr = a; m0_wdata = d;
    end else begin
      m1_req = r; m1_we = we; m1_size = sz; m1_addr = a; m1_wdata = d;
    end
  endtask

  task automatic single(input int m, input logic we, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] d);
    int lat, cyc, gnt_cyc, done_cyc, we_cnt;
    logic other;
    logic [31:0] old, exp_word, wr_addr, wr_data, first_addr, aligned;
    lat      = model_lat(we, sz);
    aligned  = {a[31:2], 2'b00};
    old      = ref_mem[a[9:2]];
    exp_word = we ? model_store(old, sz, a, d) : old;
    cyc = 0; gnt_cyc = -1; done_cyc = -1; we_cnt = 0; other = 1'b0;
    wr_addr = '0; wr_data = '0; first_addr = '0;
    drive(m, 1'b1, we, sz, a, d);
    while (done_cyc < 0 && cyc < 12) begin
      @(negedge cpu_clk);
      cyc++;
      if (cyc == 1) first_addr = bus_addr;
      if (gnt_of(m) && gnt_cyc < 0) gnt_cyc = cyc;
      if (gnt_of(1 - m) || done_of(1 - m)) other = 1'b1;
      if (bus_we) begin
        we_cnt++;
        wr_addr = bus_addr;
        wr_data = bus_wdata;
      end
      if (done_of(m)) begin
        done_cyc = cyc;
        drive(m, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
      end
    end
    drive(m, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    $display("txn m%0d we=%0d size=%0d addr=%08h wdata=%08h done@%0d", m, we, sz, a, d, done_cyc);
    check("gnt_cycle", 32'(gnt_cyc), 32'd1);
    check("done_cycle", 32'(done_cyc), 32'(lat));
    check("bus_addr", first_addr, aligned);
    check("write_count", 32'(we_cnt), 32'(we));
    if (we) begin
      check("write_addr", wr_addr, aligned);
      check("bus_wdata", wr_data, exp_word);
      ref_mem[a[9:2]] = exp_word;
    end else begin
      check("load_rdata", rdata_of(m), old);
      exp_rdata[m] = old;
    end
    check("other_rdata", rdata_of(1 - m), exp_rdata[1 - m]);
    check("other_quiet", 32'(other), 32'd0);
    check("mem_word", mem[a[9:2]], ref_mem[a[9:2]]);
    @(negedge cpu_clk);
  endtask

  task automatic stream(input int n_txn);
    logic [1:0]  rq, just_done;
    logic        cw [2];
    logic [1:0]  cs [2];
    logic [31:0] ca [2];
    logic [31:0] cd [2];
    int          exp_win, owner, n_done, cyc, gnt_at;
    logic        busy, stray;
    logic [31:0] old;
    rq = 2'b00; just_done = 2'b00; exp_win = 0; owner = 0; n_done = 0;
    cyc = 0; gnt_at = 0; busy = 1'b0; stray = 1'b0;
    while (n_done < n_txn && cyc < 2000) begin
      for (int m = 0; m < 2; m++) begin
        if (!rq[m]) begin
          if (just_done[m]) begin
            just_done[m] = 1'b0;
          end else begin
            rq[m] = 1'b1;
            cw[m] = 1'($urandom_range(1, 0));
            cs[m] = 2'($urandom_range(3, 0));
            ca[m] = $urandom_range(1023, 0);
            cd[m] = $urandom;
            drive(m, 1'b1, cw[m], cs[m], ca[m], cd[m]);
          end
        end
      end
      @(negedge cpu_clk);
      cyc++;
      if (m0_gnt || m1_gnt) begin
        check("rr_gnt", 32'({m1_gnt, m0_gnt}), (exp_win == 1) ? 32'd2 : 32'd1);
        check("rr_no_overlap", 32'(busy), 32'd0);
        owner   = m1_gnt ? 1 : 0;
        busy    = 1'b1;
        gnt_at  = cyc;
        exp_win = 1 - exp_win;
      end
      if (bus_we && !busy) stray = 1'b1;
      if (m0_done || m1_done) begin
        $display("rr m%0d we=%0d size=%0d addr=%08h wdata=%08h", owner, cw[owner], cs[owner],
                 ca[owner], cd[owner]);
        check("rr_done", 32'({m1_done, m0_done}), (owner == 1) ? 32'd2 : 32'd1);
        check("rr_lat", 32'(cyc - gnt_at), 32'(model_lat(cw[owner], cs[owner]) - 1));
        old = ref_mem[ca[owner][9:2]];
        if (cw[owner]) begin
          ref_mem[ca[owner][9:2]] = model_store(old, cs[owner], ca[owner], cd[owner]);
        end else begin
          check("rr_rdata", rdata_of(owner), old);
          exp_rdata[owner] = old;
        end
        check("rr_mem", mem[ca[owner][9:2]], ref_mem[ca[owner][9:2]]);
        check("rr_other_rdata", rdata_of(1 - owner), exp_rdata[1 - owner]);
        rq[owner]        = 1'b0;
        just_done[owner] = 1'b1;
        drive(owner, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        busy = 1'b0;
        n_done++;
      end
    end
    drive(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    check("rr_count", 32'(n_done), 32'(n_txn));
    check("rr_stray_write", 32'(stray), 32'd0);
    repeat (2) @(negedge cpu_clk);
  endtask

  initial begin
    logic quiet_bad;
    n_pass = 0;
    n_checks = 0;
    cpu_rst = 1'b1;
    mem_clr = 1'b1;
    drive(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    repeat (3) @(negedge cpu_clk);
    check("reset_gnt_done", 32'({m1_gnt, m0_gnt, m1_done, m0_done}), 32'd0);
    check("reset_bus_we", 32'(bus_we), 32'd0);
    check("reset_bus_addr", bus_addr, 32'd0);
    check("reset_bus_wdata", bus_wdata, 32'd0);
    check("reset_m0_rdata", m0_rdata, 32'd0);
    check("reset_m1_rdata", m1_rdata, 32'd0);
    cpu_rst = 1'b0;
    mem_clr = 1'b0;
    @(negedge cpu_clk);

    single(0, 1'b1, 2'b10, 32'h104, 32'hDEADBEEF);
    single(1, 1'b1, 2'b10, 32'h100, 32'h11223344);
    single(0, 1'b1, 2'b00, 32'h102, 32'h000000AA);
    single(1, 1'b1, 2'b11, 32'h200, 32'h55667788);
    single(1, 1'b1, 2'b01, 32'h203, 32'h0000BEEF);
    single(1, 1'b1, 2'b10, 32'h300, 32'hCAFEF00D);
    single(0, 1'b0, 2'b00, 32'h301, 32'h0);
    single(0, 1'b1, 2'b00, 32'h107, 32'h12345677);
    single(1, 1'b1, 2'b01, 32'h104, 32'hFFFF0001);
    single(1, 1'b0, 2'b10, 32'h106, 32'h0);
    for (int k = 0; k < 24; k++) begin
      single(int'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)),
             $urandom_range(1023, 0), $urandom);
    end

    // Reset during RCAP of a byte store: no write, no done, then normal service.
    single(1, 1'b1, 2'b10, 32'h80, 32'h0BADF00D);
    drive(0, 1'b1, 1'b1, 2'b00, 32'h81, 32'h5A);
    @(negedge cpu_clk);
    check("rst_gnt", 32'(m0_gnt), 32'd1);
    @(negedge cpu_clk);
    check("rst_rcap_addr", bus_addr, 32'h80);
    cpu_rst = 1'b1;
    drive(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    @(negedge cpu_clk);
    check("rst_bus_we", 32'(bus_we), 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_done", 32'({m1_done, m0_done}), 32'd0);
    check("rst_rdata", m1_rdata, 32'd0);
    cpu_rst = 1'b0;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    quiet_bad = 1'b0;
    repeat (6) begin
      @(negedge cpu_clk);
      if (bus_we || m0_done || m1_done || m0_gnt || m1_gnt) quiet_bad = 1'b1;
    end
    check("rst_quiet", 32'(quiet_bad), 32'd0);
    check("rst_mem_kept", mem[32], ref_mem[32]);
    single(0, 1'b1, 2'b00, 32'h81, 32'h5A);

    // Both masters streaming from a fresh reset.
    cpu_rst = 1'b1;
    repeat (2) @(negedge cpu_clk);
    cpu_rst = 1'b0;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    @(negedge cpu_clk);
    stream(24);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
